store_buffer: RTL

Word-granular write buffer between the EX/MEM pipeline register and the data memory. It absorbs stores from the MEM stage into a small FIFO and drains them to the data memory write port in program order. A drain happens only in cycles when no load is using the memory port. Loads that hit a buffered address receive forwarded data, so they always see the youngest store.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/store_buffer_if.sv | 43 ++++
 rtl/sb_fwd_match.sv | 39 +++
 rtl/store_buffer.sv | 86 ++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared memory-side types and constants for the store buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

   localparam int WORD_ADDR_HI = 31;
   localparam int WORD_ADDR_LO = 2;
   localparam int SB_DEPTH     = 4;

   typedef struct packed {
      logic                                 valid;
      logic [WORD_ADDR_HI-WORD_ADDR_LO:0]   addr;
      logic [31:0]                          data;
   } sb_entry_t;

   function automatic logic [WORD_ADDR_HI-WORD_ADDR_LO:0] wordAddr(input logic [31:0] byteAddr);
      return byteAddr[WORD_ADDR_HI:WORD_ADDR_LO];
   endfunction

endpackage

`default_nettype wire

// File: rtl/store_buffer_if.sv
// ============================================================================
// Module   : store_buffer_if
// Purpose  : Store/load/data-memory signal bundle around the store buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface store_buffer_if
   import mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
);

   logic             st_valid;
   logic [31:0]      st_addr;
   logic [31:0]      st_data;
   logic             st_ready;
   logic             ld_valid;
   logic [31:0]      ld_addr;
   logic             ld_hit;
   logic [31:0]      ld_data;
   logic             dm_we;
   logic [31:0]      dm_addr;
   logic [31:0]      dm_wdata;
   logic             empty;
   logic [PTR_W:0]   count;

   // MEM-stage side
   modport master (
      output st_valid, st_addr, st_data, ld_valid, ld_addr,
      input  st_ready, ld_hit, ld_data, dm_we, dm_addr, dm_wdata, empty, count
   );

   // Buffer side
   modport slave (
      input  st_valid, st_addr, st_data, ld_valid, ld_addr,
      output st_ready, ld_hit, ld_data, dm_we, dm_addr, dm_wdata, empty, count
   );

endinterface

`default_nettype wire

// File: rtl/sb_fwd_match.sv
// ============================================================================
// Module   : sb_fwd_match
// Purpose  : Youngest-match store-to-load forwarding search over buffer entries.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sb_fwd_match
   import mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  sb_entry_t                           i_entries [DEPTH],
   input  logic [PTR_W-1:0]                    i_tailPtr,
   input  logic [WORD_ADDR_HI-WORD_ADDR_LO:0]  i_ldWordAddr,
   output logic                                o_hit,
   output logic [31:0]                         o_data
);

   logic [PTR_W-1:0] w_idx;

   // Walk from tail-1 (youngest) back towards the oldest; first match wins.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      w_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = i_tailPtr - PTR_W'(i + 1);
         if (!o_hit && i_entries[w_idx].valid && (i_entries[w_idx].addr == i_ldWordAddr)) begin
            o_hit  = 1'b1;
            o_data = i_entries[w_idx].data;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module   : store_buffer
// Purpose  : In-order word store FIFO draining to data memory when no load
//            uses the port, with youngest-entry load forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_buffer
   import mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   store_buffer_if.slave   sb
);

   sb_entry_t                           r_entries [DEPTH];
   logic [PTR_W-1:0]                    r_head;
   logic [PTR_W-1:0]                    r_tail;
   logic [PTR_W:0]                      r_count;

   logic                                w_enq;
   logic                                w_drain;
   logic                                w_notEmpty;
   logic [WORD_ADDR_HI-WORD_ADDR_LO:0]  w_ldWordAddr;
   logic                                w_unusedAddrBits;

   assign w_notEmpty   = (r_count != '0);
   // Full is judged on current occupancy only; a same-cycle drain does not free a slot.
   assign sb.st_ready  = (r_count != (PTR_W+1)'(DEPTH));
   assign w_enq        = sb.st_valid && sb.st_ready;
   assign w_drain      = w_notEmpty && !sb.ld_valid;

   assign sb.empty     = !w_notEmpty;
   assign sb.count     = r_count;
   assign sb.dm_we     = w_drain;
   assign sb.dm_addr   = {r_entries[r_head].addr, 2'b00};
   assign sb.dm_wdata  = r_entries[r_head].data;

   assign w_ldWordAddr     = wordAddr(sb.ld_addr);
   assign w_unusedAddrBits = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entries[i] <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) begin
            r_entries[r_tail].valid <= 1'b1;
            r_entries[r_tail].addr  <= wordAddr(sb.st_addr);
            r_entries[r_tail].data  <= sb.st_data;
            r_tail                  <= r_tail + 1'b1;
         end
         if (w_drain) begin
            r_entries[r_head].valid <= 1'b0;
            r_head                  <= r_head + 1'b1;
         end
         case ({w_enq, w_drain})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   sb_fwd_match #(
      .DEPTH        (DEPTH),
      .PTR_W        (PTR_W)
   ) u_fwdMatch (
      .i_entries    (r_entries),
      .i_tailPtr    (r_tail),
      .i_ldWordAddr (w_ldWordAddr),
      .o_hit        (sb.ld_hit),
      .o_data       (sb.ld_data)
   );

endmodule

`default_nettype wire
